puf_challenge_sweeper: RTL and testbench

PUF_CHALLENGE_SWEEPER -- requirements
Module: puf_challenge_sweeper

---
 rtl/puf_challenge_sweeper.sv | 137 +++++++++++++
 tb/tb_puf_challenge_sweeper.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/puf_challenge_sweeper.sv
// Sweeps all eight PUF challenges, pulsing the PUF reset before each one,
// and collects the response bits into an 8-bit signature.
module puf_challenge_sweeper #(
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       puf_response,
  input  logic       puf_finished,
  output logic       puf_rst,
  output logic [2:0] challenge,
  output logic [7:0] signature,
  output logic       valid,
  output logic       busy,
  output logic       timeout_err
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RW-1:0] RLAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic [2:0]    chal_q, chal_d;
  logic [7:0]    sig_q, sig_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          terr_q, terr_d;
  logic          prst_q, prst_d;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    wcnt_d  = wcnt_q;
    chal_d  = chal_q;
    sig_d   = sig_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    terr_d  = terr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_APPLY;
          rcnt_d  = '0;
          chal_d  = 3'd0;
          sig_d   = 8'h00;
          valid_d = 1'b0;
          terr_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_APPLY: begin
        if (rcnt_q == RLAST) begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + RW'(1);
        end
      end
      S_WAIT: begin
        // capture and advance share one edge
        if (puf_finished) begin
          sig_d[chal_q] = puf_response;
          if (chal_q == 3'd7) begin
            state_d = S_DONE;
          end else begin
            chal_d  = chal_q + 3'd1;
            rcnt_d  = '0;
            state_d = S_APPLY;
          end
        end else if (wcnt_q == TLAST) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    prst_d = (state_d == S_APPLY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
      chal_q  <= 3'd0;
      sig_q   <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      prst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
      chal_q  <= chal_d;
      sig_q   <= sig_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      prst_q  <= prst_d;
    end
  end

  assign puf_rst     = prst_q;
  assign challenge   = chal_q;
  assign signature   = sig_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_puf_challenge_sweeper.sv
// Directed and randomized sweeps against a cycle-count model of the
// sweeper driving a behavioural PUF with per-challenge finish delays.
module tb_puf_challenge_sweeper;

  localparam int RC = 2;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       puf_response;
  logic       puf_finished;
  logic       puf_rst;
  logic [2:0] challenge;
  logic [7:0] signature;
  logic       valid;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int failures = 0;

  // PUF behaviour: finish delay in WAIT cycles (0 = never) and response bits
  int       d [8];
  logic [7:0] resp;
  int       k = 0;

  puf_challenge_sweeper #(
    .RST_CYCLES(RC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .puf_response(puf_response),
    .puf_finished(puf_finished),
    .puf_rst(puf_rst),
    .challenge(challenge),
    .signature(signature),
    .valid(valid),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic puf_step();
    if (puf_rst) k = 0;
    else k++;
    puf_finished = (d[challenge] != 0) && (k >= d[challenge]);
    puf_response = resp[challenge];
  endtask

  task automatic set_nominal();
    for (int i = 0; i < 8; i++) d[i] = 1;
    resp = 8'hAA;
  endtask

  task automatic sweep(input bit noisy);
    int t, exp_edge, exp_chal, edge_n, pulses, hi;
    bit exp_to, busy_ok, prev;
    logic [7:0] exp_sig;
    t = 0;
    exp_to = 0;
    exp_chal = 7;
    exp_sig = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (d[i] == 0 || d[i] > TO) begin
        t += RC + TO;
        exp_to = 1;
        exp_chal = i;
        break;
      end
      t += RC + d[i];
      exp_sig[i] = resp[i];
    end
    exp_edge = exp_to ? t : t + 1;

    start = 1'b1;
    puf_finished = 1'b0;
    tick();
    start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_valid", 32'(valid), 32'd0);
    chk("accept_terr", 32'(timeout_err), 32'd0);
    chk("accept_sig", 32'(signature), 32'd0);
    chk("accept_chal", 32'(challenge), 32'd0);

    edge_n = 0;
    pulses = puf_rst ? 1 : 0;
    hi = pulses;
    prev = puf_rst;
    busy_ok = 1;
    while (!valid && !timeout_err && edge_n < 400) begin
      puf_step();
      if (noisy) start = ($urandom_range(0, 2) == 0);
      tick();
      edge_n++;
      if (puf_rst) begin
        hi++;
        if (!prev) pulses++;
      end
      prev = puf_rst;
      if (!valid && !timeout_err && !busy) busy_ok = 0;
    end
    start = 1'b0;
    puf_finished = 1'b0;

    chk("end_edge", 32'(edge_n), 32'(exp_edge));
    chk("signature", 32'(signature), 32'(exp_sig));
    chk("valid", 32'(valid), 32'(!exp_to));
    chk("timeout_err", 32'(timeout_err), 32'(exp_to));
    chk("busy_end", 32'(busy), 32'd0);
    chk("busy_held", 32'(busy_ok), 32'd1);
    chk("challenge_end", 32'(challenge), 32'(exp_chal));
    chk("puf_rst_end", 32'(puf_rst), 32'd0);
    chk("rst_pulses", 32'(pulses), 32'(exp_chal + 1));
    chk("rst_hi_cycles", 32'(hi), 32'(RC * (exp_chal + 1)));
  endtask

  task automatic hold(input int n);
    logic [7:0] s0;
    logic v0, e0;
    s0 = signature;
    v0 = valid;
    e0 = timeout_err;
    for (int i = 0; i < n; i++) begin
      puf_finished = 1'($urandom);
      puf_response = 1'($urandom);
      tick();
      chk("hold", {22'd0, busy, e0 ^ timeout_err, v0 ^ valid,
                   s0 ^ signature}, 32'd0);
    end
    puf_finished = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    puf_response = 1'b0;
    puf_finished = 1'b0;
    set_nominal();
    tick();
    tick();
    chk("reset_outputs", {20'd0, puf_rst, challenge, signature, valid,
                          busy, timeout_err}, 32'd0);
    rst = 1'b0;
    tick();

    // nominal: valid at edge 25, signature AA
    set_nominal();
    sweep(0);
    hold(3);

    // late finish on challenge 3
    for (int i = 0; i < 8; i++) d[i] = 1;
    d[3] = 5;
    resp = 8'h08;
    sweep(0);

    // timeout on challenge 2 with partial capture
    set_nominal();
    resp = 8'hFF;
    d[2] = 0;
    sweep(0);
    hold(2);

    // finish on the last permitted WAIT cycle
    set_nominal();
    d[5] = TO;
    sweep(0);

    // start one cycle after valid, plus noise starts while busy
    set_nominal();
    sweep(1);

    // reset during WAIT of challenge 4
    set_nominal();
    d[4] = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(challenge == 3'd4 && !puf_rst && busy) && n < 200) begin
      puf_step();
      tick();
      n++;
    end
    chk("reach_wait4", 32'(n < 200), 32'd1);
    puf_step();
    tick();
    rst = 1'b1;
    puf_finished = 1'b1;
    tick();
    chk("midreset_outputs", {20'd0, puf_rst, challenge, signature, valid,
                             busy, timeout_err}, 32'd0);
    rst = 1'b0;
    puf_finished = 1'b0;
    tick();
    set_nominal();
    sweep(0);

    // randomized sweeps
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 8; i++)
        d[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 18) : 1;
      resp = 8'($urandom);
      sweep(1);
      if ($urandom_range(0, 1) == 1) hold($urandom_range(1, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
